// File: rtl/neural_pipeline_pkg.sv
// Shared definitions for the spike pipeline run-control sequencer:
// state encoding, default timing constants and the default bin count width.
package neural_pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int STATE_W               = 2;
    localparam int DEFAULT_WARMUP_CYCLES = 150000;
    localparam int DEFAULT_BIN_CYCLES    = 1500;
    localparam int DEFAULT_CNT_W         = 16;

endpackage

// File: rtl/neural_pipeline_sequencer_bin_holding_reg.sv
// Valid/ready holding register for closed bin counts. A newly closed bin
// always wins; overwriting an undelivered bin raises a sticky overrun flag
// that is only cleared when a new run is started.
module bin_holding_reg
    import neural_pipeline_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_overrun,
    input  logic             load,
    input  logic [CNT_W-1:0] load_data,
    input  logic             ready,
    output logic [CNT_W-1:0] data,
    output logic             valid,
    output logic             overrun
);

    // Capture bins, track delivery and flag bins lost to overwrite
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (clear_overrun) begin
                overrun <= 1'b0;
            end else if (load && valid && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/neural_pipeline_sequencer.sv
// Run-control sequencer for the single-channel spike pipeline: start/stop
// FSM, warm-up hold-off, fixed-length counting bins and hand-off of each
// closed bin count to the velocity decoder.
module neural_pipeline_sequencer
    import neural_pipeline_pkg::*;
#(
    parameter int WARMUP_CYCLES = DEFAULT_WARMUP_CYCLES,
    parameter int BIN_CYCLES    = DEFAULT_BIN_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             spike_in,
    output logic             spike_gated,
    output logic [CNT_W-1:0] bin_count,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             overrun,
    output logic [1:0]       state,
    output logic             busy
);

    localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
    localparam logic [STATE_W-1:0] S_WARMUP = WARMUP;
    localparam logic [STATE_W-1:0] S_RUN    = RUN;
    localparam logic [STATE_W-1:0] S_DRAIN  = DRAIN;

    // Warm-up counter may reach WARMUP_CYCLES, so size it for that value
    localparam int WARM_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int TIMER_W = $clog2(BIN_CYCLES);

    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIN_CYCLES - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WARM_W-1:0]  warm_cnt;
    logic [TIMER_W-1:0] bin_timer;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   acc_inc;
    logic               counting;
    logic               close_bin;
    logic               start_run;

    assign counting  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign close_bin = counting && (bin_timer == TIMER_LAST);
    assign start_run = (state_q == S_IDLE) && start && !stop;
    assign acc_inc   = (spike_in && (acc != '1)) ? acc + CNT_W'(1) : acc;
    assign state     = state_q;

    // Next-state decode: stop overrides start, drain ends after its bin closes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_run) state_d = S_WARMUP;
            S_WARMUP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (warm_cnt == WARM_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:    if (stop) state_d = S_RUN | S_DRAIN;
            S_DRAIN:  if (close_bin) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register plus registered busy flag and gated spike output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            spike_gated <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d != S_IDLE);
            spike_gated <= spike_in && counting;
        end
    end

    // Warm-up counter, restarted whenever a new run begins
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            warm_cnt <= '0;
        end else if (state_q == S_WARMUP) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Bin timer: held at zero outside counting, wraps after each close
    always_ff @(posedge clk) begin
        if (rst || !counting || close_bin) begin
            bin_timer <= '0;
        end else begin
            bin_timer <= bin_timer + TIMER_W'(1);
        end
    end

    // Saturating spike accumulator, emptied into the holding register on close
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            acc <= '0;
        end else if (counting) begin
            acc <= close_bin ? '0 : acc_inc;
        end
    end

    bin_holding_reg #(
        .CNT_W(CNT_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .clear_overrun(start_run),
        .load         (close_bin),
        .load_data    (acc_inc),
        .ready        (bin_ready),
        .data         (bin_count),
        .valid        (bin_valid),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_neural_pipeline_sequencer.sv
// Scoreboard bench for neural_pipeline_sequencer: a behavioural run model
// predicts every post-edge output; a monitor compares the DUT against it.
module tb_neural_pipeline_sequencer;

    localparam int WARM = 10;
    localparam int BIN  = 8;

    typedef struct packed {
        logic [1:0] st;
        logic       busy;
        logic       gated;
        logic [3:0] cnt;
        logic [1:0] cnt2;
        logic       valid;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       spike_in = 1'b0;
    logic       bin_ready = 1'b0;
    logic       spike_gated, bin_valid, overrun, busy;
    logic [3:0] bin_count;
    logic [1:0] state;
    logic       spike_gated2, bin_valid2, overrun2, busy2;
    logic [1:0] bin_count2;
    logic [1:0] state2;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Behavioural model: phase, cycles elapsed, unbounded spike sum
    int mMode, mWarm, mRun, mSum, mCnt, mCnt2, mValid, mOv, mGated;

    neural_pipeline_sequencer #(.WARMUP_CYCLES(WARM), .BIN_CYCLES(BIN), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .spike_in(spike_in),
        .spike_gated(spike_gated), .bin_count(bin_count), .bin_valid(bin_valid),
        .bin_ready(bin_ready), .overrun(overrun), .state(state), .busy(busy)
    );

    neural_pipeline_sequencer #(.WARMUP_CYCLES(WARM), .BIN_CYCLES(BIN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .spike_in(spike_in),
        .spike_gated(spike_gated2), .bin_count(bin_count2), .bin_valid(bin_valid2),
        .bin_ready(bin_ready), .overrun(overrun2), .state(state2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Compare every DUT output against one predicted snapshot
    task automatic checkOutput(input exp_t e);
        cmp("state", state, e.st);
        cmp("busy", busy, e.busy);
        cmp("spike_gated", spike_gated, e.gated);
        cmp("bin_count", bin_count, e.cnt);
        cmp("bin_valid", bin_valid, e.valid);
        cmp("overrun", overrun, e.ov);
        cmp("sat_bin_count", bin_count2, e.cnt2);
        cmp("sat_state", state2, e.st);
        cmp("sat_bin_valid", bin_valid2, e.valid);
        cmp("sat_overrun", overrun2, e.ov);
        cmp("sat_busy", busy2, e.busy);
        cmp("sat_spike_gated", spike_gated2, e.gated);
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected result
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic sp, input logic rd);
        bit   load;
        int   lv;
        exp_t e;
        @(negedge clk);
        rst = r; start = s; stop = p; spike_in = sp; bin_ready = rd;
        load = 0;
        lv = 0;
        if (r) begin
            mMode = 0; mWarm = 0; mRun = 0; mSum = 0;
            mCnt = 0; mCnt2 = 0; mValid = 0; mOv = 0; mGated = 0;
        end else begin
            mGated = (sp && mMode >= 2) ? 1 : 0;
            if (mMode >= 2) begin
                mSum += sp;
                if (mRun % BIN == BIN - 1) begin
                    load = 1;
                    lv = mSum;
                    mSum = 0;
                end
                mRun++;
            end
            if (load) begin
                if (mValid == 1 && !rd) mOv = 1;
                mCnt = minInt(lv, 15);
                mCnt2 = minInt(lv, 3);
                mValid = 1;
            end else if (mValid == 1 && rd) begin
                mValid = 0;
            end
            case (mMode)
                0: if (s && !p) begin
                    mMode = 1; mWarm = 0; mRun = 0; mSum = 0; mOv = 0;
                end
                1: if (p) mMode = 0;
                   else begin
                       mWarm++;
                       if (mWarm == WARM) begin
                           mMode = 2;
                           mRun = 0;
                       end
                   end
                2: if (p) mMode = 3;
                default: if (load) mMode = 0;
            endcase
        end
        e.st    = 2'(mMode);
        e.busy  = (mMode != 0);
        e.gated = 1'(mGated);
        e.cnt   = 4'(mCnt);
        e.cnt2  = 2'(mCnt2);
        e.valid = 1'(mValid);
        e.ov    = 1'(mOv);
        expQ.push_back(e);
    endtask

    // Monitor: pop and compare the prediction just after each active edge
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        repeat (3) applyStimulus(1, 0, 0, 0, 0);

        // Start, ready, spike every cycle: first bins are 8 (saturating to 3)
        applyStimulus(0, 1, 0, 1, 1);
        repeat (30) applyStimulus(0, 0, 0, 1, 1);

        // Stop mid-bin, drain closes that bin then returns to idle
        applyStimulus(0, 0, 1, 1, 1);
        repeat (12) applyStimulus(0, 0, 0, 1, 1);

        // Spikes only during warm-up, then silence: first bin is 0
        applyStimulus(0, 1, 0, 1, 1);
        repeat (10) applyStimulus(0, 0, 0, 1, 1);
        repeat (8) applyStimulus(0, 0, 0, 0, 1);

        // Decoder stalls across two closes, then one accept, then drain
        repeat (18) applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 1);

        // Start and stop together in idle are ignored
        applyStimulus(0, 0, 1, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 1);
        repeat (3) applyStimulus(0, 0, 0, 1, 1);

        // Reset in the middle of a run with a pending bin
        applyStimulus(0, 1, 0, 1, 0);
        repeat (22) applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 1);

        // Randomized run control, spikes and back-pressure
        repeat (2000) begin
            applyStimulus(1'($urandom_range(0, 499) == 0),
                          1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
        end

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
